common_dffram_wrsched: RTL and testbench
========================================

Name: common_dffram_wrsched

Overview:
- Write-port scheduler for the 1-write/2-read DFF RAM.
- Shares the single write port (port A: addr, en, bit-WE, din) between two valid/ready write requesters using round-robin arbitration.
- Runs a clear sweep that writes CLEAR_VALUE to every entry after reset and on request.
- Sits between producers (e.g. two writeback sources) and the RAM instance. Read ports B/C are untouched.

Parameters:
- RAM_DATA_WIDTH, 8, entry width in bits; must match the RAM.
- RAM_ADDR_WIDTH, 4, address width; depth = 2^RAM_ADDR_WIDTH.
- CLEAR_VALUE, all zeros (RAM_DATA_WIDTH bits), value written to every entry during a clear sweep.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a write.
- req0_ready  out  1  requester 0 write accepted this cycle when valid && ready.
- req0_addr  in  RAM_ADDR_WIDTH  requester 0 address.
- req0_wbe  in  RAM_DATA_WIDTH  requester 0 bit write enables.
- req0_data  in  RAM_DATA_WIDTH  requester 0 data.
- req1_valid / req1_ready / req1_addr / req1_wbe / req1_data  same as requester 0, for requester 1.
- clr_req  in  1  request a full clear sweep (single-cycle pulse or level).
- busy  out  1  high while a clear sweep is in progress.
- clr_done  out  1  one-cycle pulse in the cycle the last entry is cleared.
- ram_addra  out  RAM_ADDR_WIDTH  to RAM port A address.
- ram_ena  out  1  to RAM port A enable.
- ram_wea  out  RAM_DATA_WIDTH  to RAM port A bit write enables.
- ram_dina  out  RAM_DATA_WIDTH  to RAM port A data.

Behaviour:
- Registered state: fsm in {CLEAR, RUN}, clr_cnt[RAM_ADDR_WIDTH-1:0], rr_ptr (1 bit: requester with priority).
- Reset asserted (reset=0): fsm=CLEAR, clr_cnt=0, rr_ptr=0. Consequently busy=1, req0_ready=req1_ready=0, clr_done=0, ram_ena=1, ram_addra=0, ram_wea=all ones, ram_dina=CLEAR_VALUE. The RAM is held in its own reset, so these writes are harmless.
- CLEAR:
  - Each cycle: ram_ena=1, ram_addra=clr_cnt, ram_wea=all ones, ram_dina=CLEAR_VALUE; clr_cnt++.
  - When clr_cnt == DEPTH-1: clr_done=1 this cycle, next state RUN, clr_cnt wraps to 0.
  - Sweep takes exactly DEPTH cycles.
  - Both ready outputs are 0 throughout; clr_req is ignored (no restart).
- RUN:
  - Combinational path from requests to ram_* outputs; zero-latency. An accepted write is committed at the same clock edge as its handshake.
  - Only one valid: that requester gets ready=1 and its addr/wbe/data drive the RAM port; ram_ena=1.
  - Both valid: the requester indicated by rr_ptr gets ready=1, the other gets ready=0.
  - After any grant: rr_ptr = index of the non-granted requester, i.e. it flips away from the granted one. With no grant, rr_ptr holds.
  - No valid: ram_ena=0, ram_wea=0, ram_addra=0, ram_dina=0.
  - Granted request with wbe=0: still handshakes; ram_ena=1 with wea=0 (no bits change).
- clr_req=1 in RUN:
  - No grant that cycle; both ready=0 and ram_ena=0.
  - Next state CLEAR with clr_cnt=0; rr_ptr holds.
  - Pending valid requests stay pending; requesters must keep valid and payload stable until ready.
- Requester rule: valid must not drop, and payload must not change, while valid && !ready. The scheduler does not check this.
- Same address from both requesters: no merge; served in two consecutive grants in round-robin order.
- Reset asserted mid-sweep or mid-traffic: immediately return to reset state; any request not yet handshaken is dropped.
- busy is a direct decode of fsm==CLEAR; clr_done is a decode of CLEAR && clr_cnt==DEPTH-1.

Decomposition:
- Shared package: fsm state encoding (CLEAR=1'b0, RUN=1'b1).
- Sub-module common_rr_arb2: 2-way round-robin arbiter (valid[1:0] in; grant[1:0] out; internal pointer with advance enable). Reusable for other shared ports.
- Top holds the clear FSM/counter and the output mux.

Test Plan:
- Reset release, DEPTH=16 -> busy=1 for 16 cycles; ram_addra steps 0..15 with wea=0xFF, dina=CLEAR_VALUE; clr_done pulses at addr 15; then busy=0. Readback through the RAM read ports shows all 0.
- RUN, req0 only, addr=3, wbe=0x0F, data=0xA5 -> req0_ready=1 same cycle; ram_addra=3, ram_wea=0x0F, ram_dina=0xA5; RAM entry 3 reads 0x05 next cycle.
- Both valid continuously, 4 writes each, rr_ptr=0 -> grants alternate 0,1,0,1,...; each requester is held off at most one cycle.
- clr_req while both valid -> no grant that cycle; 16-cycle sweep with ready=0 throughout; then grants resume starting at the held rr_ptr; all entries read CLEAR_VALUE before new writes.
- reset asserted mid-sweep at clr_cnt=7 -> all outputs return to reset values immediately; after release a full 16-cycle sweep restarts from addr 0.
- Both valid, same addr=9, req0 data 0x11 / req1 data 0x22, wbe=0xFF -> two consecutive writes; final entry 9 holds the second grant's data.

Source files
------------

// File: rtl/common_dffram_wrsched_pkg.sv
// Shared types for the DFF RAM write-port scheduler.
// FSM encoding used by the top and the bench.
package common_dffram_wrsched_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } fsm_t;

endpackage

// File: rtl/common_rr_arb2.sv
// Two-way round-robin arbiter with enable.
// ptr names the requester that wins a tie; it flips away from each winner.
module common_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output logic       ptr
);

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= 1'b0;
    end else if (|grant) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/common_dffram_wrsched.sv
// Write-port scheduler: round-robin between two writers onto
// RAM port A, plus a full clear sweep after reset or on request.
module common_dffram_wrsched
  import common_dffram_wrsched_pkg::*;
#(
  parameter int RAM_DATA_WIDTH = 8,
  parameter int RAM_ADDR_WIDTH = 4,
  parameter logic [RAM_DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic [RAM_ADDR_WIDTH-1:0] req0_addr,
  input  logic [RAM_DATA_WIDTH-1:0] req0_wbe,
  input  logic [RAM_DATA_WIDTH-1:0] req0_data,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic [RAM_ADDR_WIDTH-1:0] req1_addr,
  input  logic [RAM_DATA_WIDTH-1:0] req1_wbe,
  input  logic [RAM_DATA_WIDTH-1:0] req1_data,
  input  logic                      clr_req,
  output logic                      busy,
  output logic                      clr_done,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addra,
  output logic                      ram_ena,
  output logic [RAM_DATA_WIDTH-1:0] ram_wea,
  output logic [RAM_DATA_WIDTH-1:0] ram_dina
);

  localparam logic [RAM_ADDR_WIDTH-1:0] LAST = '1;

  fsm_t                      fsm;
  fsm_t                      fsm_nxt;
  logic [RAM_ADDR_WIDTH-1:0] clr_cnt;
  logic [RAM_ADDR_WIDTH-1:0] cnt_nxt;
  logic                      arb_en;
  logic [1:0]                grant;
  logic                      rr_ptr;

  // A clear request steals the cycle: nobody is granted.
  assign arb_en = (fsm == RUN) && !clr_req;

  common_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .valid ({req1_valid, req0_valid}),
    .grant (grant),
    .ptr   (rr_ptr)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm     <= CLEAR;
      clr_cnt <= '0;
    end else begin
      fsm     <= fsm_nxt;
      clr_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    fsm_nxt   = fsm;
    cnt_nxt   = clr_cnt;
    busy      = 1'b0;
    clr_done  = 1'b0;
    ram_ena   = 1'b0;
    ram_addra = '0;
    ram_wea   = '0;
    ram_dina  = '0;
    unique case (fsm)
      CLEAR: begin
        busy      = 1'b1;
        ram_ena   = 1'b1;
        ram_addra = clr_cnt;
        ram_wea   = '1;
        ram_dina  = CLEAR_VALUE;
        cnt_nxt   = clr_cnt + 1'b1;
        if (clr_cnt == LAST) begin
          clr_done = 1'b1;
          fsm_nxt  = RUN;
        end
      end
      RUN: begin
        if (clr_req) begin
          fsm_nxt = CLEAR;
          cnt_nxt = '0;
        end else if (grant[0]) begin
          ram_ena   = 1'b1;
          ram_addra = req0_addr;
          ram_wea   = req0_wbe;
          ram_dina  = req0_data;
        end else if (grant[1]) begin
          ram_ena   = 1'b1;
          ram_addra = req1_addr;
          ram_wea   = req1_wbe;
          ram_dina  = req1_data;
        end
      end
      default: fsm_nxt = CLEAR;
    endcase
  end

endmodule

// File: tb/tb_common_dffram_wrsched.sv
// Self-checking bench for the write-port scheduler.
// Keeps its own RAM image fed from port A and a rule-level model.
module tb_common_dffram_wrsched;

  logic       clk;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_addr, req1_addr;
  logic [7:0] req0_wbe, req0_data, req1_wbe, req1_data;
  logic       clr_req, busy, clr_done, ram_ena;
  logic [3:0] ram_addra;
  logic [7:0] ram_wea, ram_dina;

  common_dffram_wrsched dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_wbe   (req0_wbe),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_wbe   (req1_wbe),
    .req1_data  (req1_data),
    .clr_req    (clr_req),
    .busy       (busy),
    .clr_done   (clr_done),
    .ram_addra  (ram_addra),
    .ram_ena    (ram_ena),
    .ram_wea    (ram_wea),
    .ram_dina   (ram_dina)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [24:0] outs;
  assign outs = {req0_ready, req1_ready, ram_ena, busy, clr_done,
                 ram_addra, ram_wea, ram_dina};

  // Model: sweeping flag, sweep index, tie-winner, expected RAM image
  bit         m_sweep;
  int         m_idx;
  bit         m_ptr;
  logic [7:0] mmem [16];
  logic [7:0] tbmem [16];
  int         dut_grant;
  int         mgrant;

  typedef struct {
    logic       v0, v1;
    logic [3:0] a0, a1;
    logic [7:0] w0, d0, w1, d1;
    logic [24:0] exp;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [24:0] pk(bit r0, bit r1, bit ena, bit bsy,
                                     bit dn, logic [3:0] a,
                                     logic [7:0] w, logic [7:0] d);
    return {r0, r1, ena, bsy, dn, a, w, d};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_exp(output logic [24:0] e, output int g);
    g = -1;
    e = '0;
    if (m_sweep) begin
      e = pk(0, 0, 1, 1, m_idx == 15, m_idx[3:0], 8'hFF, 8'h00);
    end else if (!clr_req) begin
      if (req0_valid && req1_valid) g = m_ptr ? 1 : 0;
      else if (req0_valid) g = 0;
      else if (req1_valid) g = 1;
      if (g == 0) e = pk(1, 0, 1, 0, 0, req0_addr, req0_wbe, req0_data);
      if (g == 1) e = pk(0, 1, 1, 0, 0, req1_addr, req1_wbe, req1_data);
    end
  endtask

  task automatic model_step(int g);
    if (m_sweep) begin
      mmem[m_idx] = 8'h00;
      if (m_idx == 15) begin
        m_sweep = 0;
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end else if (clr_req) begin
      m_sweep = 1;
      m_idx = 0;
    end else if (g == 0) begin
      mmem[req0_addr] = (mmem[req0_addr] & ~req0_wbe) | (req0_data & req0_wbe);
      m_ptr = 1;
    end else if (g == 1) begin
      mmem[req1_addr] = (mmem[req1_addr] & ~req1_wbe) | (req1_data & req1_wbe);
      m_ptr = 0;
    end
  endtask

  task automatic cycle(string nm, bit hand, logic [24:0] hexp);
    logic [24:0] e;
    int g;
    @(negedge clk);
    model_exp(e, g);
    chk(nm, {7'd0, outs}, {7'd0, hand ? hexp : e});
    dut_grant = req0_ready ? 0 : (req1_ready ? 1 : -1);
    if (ram_ena)
      tbmem[ram_addra] = (tbmem[ram_addra] & ~ram_wea) | (ram_dina & ram_wea);
    model_step(g);
    mgrant = g;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; clr_req = 0;
    req0_addr = 0; req0_wbe = 0; req0_data = 0;
    req1_addr = 0; req1_wbe = 0; req1_data = 0;
  endtask

  task automatic hand_sweep(string nm);
    for (int i = 0; i < 16; i++)
      cycle(nm, 1, pk(0, 0, 1, 1, i == 15, 4'(i), 8'hFF, 8'h00));
  endtask

  task automatic mem_vs_model(string nm);
    for (int i = 0; i < 16; i++) chk(nm, {24'd0, tbmem[i]}, {24'd0, mmem[i]});
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mmem[i] = 8'h5A;
      tbmem[i] = 8'h5A;
    end
    // {v0,v1,a0,a1,w0,d0,w1,d1,exp}; tie-winner starts at requester 0
    tbl[0] = '{1, 0, 4'd3, 4'd0, 8'h0F, 8'hA5, 8'h00, 8'h00,
               pk(1, 0, 1, 0, 0, 4'd3, 8'h0F, 8'hA5)};
    tbl[1] = '{0, 0, 4'd0, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00,
               pk(0, 0, 0, 0, 0, 4'd0, 8'h00, 8'h00)};
    tbl[2] = '{1, 1, 4'd1, 4'd2, 8'hFF, 8'h11, 8'hF0, 8'h22,
               pk(0, 1, 1, 0, 0, 4'd2, 8'hF0, 8'h22)};
    tbl[3] = '{1, 1, 4'd1, 4'd2, 8'hFF, 8'h11, 8'hF0, 8'h22,
               pk(1, 0, 1, 0, 0, 4'd1, 8'hFF, 8'h11)};
    tbl[4] = '{0, 1, 4'd0, 4'd9, 8'h00, 8'h00, 8'h00, 8'h77,
               pk(0, 1, 1, 0, 0, 4'd9, 8'h00, 8'h77)};
    tbl[5] = '{1, 0, 4'd15, 4'd0, 8'hAA, 8'hFF, 8'h00, 8'h00,
               pk(1, 0, 1, 0, 0, 4'd15, 8'hAA, 8'hFF)};
    tbl[6] = '{0, 1, 4'd0, 4'd4, 8'h00, 8'h00, 8'hFF, 8'h44,
               pk(0, 1, 1, 0, 0, 4'd4, 8'hFF, 8'h44)};

    // Reset state, with both requesters pushing
    idle_inputs();
    reset = 0;
    req0_valid = 1; req1_valid = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {7'd0, outs}, {7'd0, pk(0, 0, 1, 1, 0, 4'd0, 8'hFF, 8'h00)});
    idle_inputs();
    reset = 1;
    m_sweep = 1; m_idx = 0; m_ptr = 0;

    hand_sweep("init_sweep");
    cycle("post_sweep_idle", 1, pk(0, 0, 0, 0, 0, 4'd0, 8'h00, 8'h00));
    for (int i = 0; i < 16; i++) chk("init_clr_mem", {24'd0, tbmem[i]}, 32'd0);

    // Table vectors
    for (int i = 0; i < 7; i++) begin
      req0_valid = tbl[i].v0; req1_valid = tbl[i].v1;
      req0_addr = tbl[i].a0; req0_wbe = tbl[i].w0; req0_data = tbl[i].d0;
      req1_addr = tbl[i].a1; req1_wbe = tbl[i].w1; req1_data = tbl[i].d1;
      cycle($sformatf("vec%0d", i), 1, tbl[i].exp);
    end
    idle_inputs();
    chk("mem3", {24'd0, tbmem[3]}, 32'h05);
    chk("mem2", {24'd0, tbmem[2]}, 32'h20);
    chk("mem1", {24'd0, tbmem[1]}, 32'h11);
    chk("mem9_wbe0", {24'd0, tbmem[9]}, 32'h00);
    chk("mem15", {24'd0, tbmem[15]}, 32'hAA);
    mem_vs_model("tbl_mem");

    // Alternation: both always valid, four writes each
    begin
      int n0, n1, k;
      n0 = 0; n1 = 0; k = 0;
      for (int c = 0; c < 20 && (n0 < 4 || n1 < 4); c++) begin
        req0_valid = n0 < 4; req0_addr = 4'(n0);
        req0_wbe = 8'hFF; req0_data = 8'(8'h10 + n0);
        req1_valid = n1 < 4; req1_addr = 4'(8 + n1);
        req1_wbe = 8'hFF; req1_data = 8'(8'h20 + n1);
        cycle("alt_out", 0, '0);
        if (dut_grant >= 0) begin
          chk("alt_grant", dut_grant, k % 2);
          k++;
          if (dut_grant == 0) n0++;
          else n1++;
        end
      end
      chk("alt_n0", n0, 4);
      chk("alt_n1", n1, 4);
    end

    // Clear request while both are waiting
    req0_valid = 1; req0_addr = 4'd5; req0_wbe = 8'hFF; req0_data = 8'h55;
    req1_valid = 1; req1_addr = 4'd6; req1_wbe = 8'hFF; req1_data = 8'h66;
    clr_req = 1;
    cycle("clr_nogrant", 1, pk(0, 0, 0, 0, 0, 4'd0, 8'h00, 8'h00));
    clr_req = 0;
    hand_sweep("clr_sweep");
    for (int i = 0; i < 16; i++) chk("clr_mem", {24'd0, tbmem[i]}, 32'd0);
    cycle("clr_resume0", 1, pk(1, 0, 1, 0, 0, 4'd5, 8'hFF, 8'h55));
    req0_valid = 0;
    cycle("clr_resume1", 1, pk(0, 1, 1, 0, 0, 4'd6, 8'hFF, 8'h66));
    idle_inputs();

    // Reset in the middle of a sweep
    clr_req = 1;
    cycle("mid_clr", 0, '0);
    clr_req = 0;
    for (int i = 0; i < 7; i++) cycle("mid_sweep", 0, '0);
    chk("pre_rst_addr", {28'd0, ram_addra}, 32'd7);
    reset = 0;
    #1;
    chk("rst_mid", {7'd0, outs}, {7'd0, pk(0, 0, 1, 1, 0, 4'd0, 8'hFF, 8'h00)});
    @(posedge clk);
    #1;
    reset = 1;
    m_sweep = 1; m_idx = 0; m_ptr = 0;
    hand_sweep("restart_sweep");

    // Same address from both sides
    req0_valid = 1; req0_addr = 4'd9; req0_wbe = 8'hFF; req0_data = 8'h11;
    req1_valid = 1; req1_addr = 4'd9; req1_wbe = 8'hFF; req1_data = 8'h22;
    cycle("same_a0", 1, pk(1, 0, 1, 0, 0, 4'd9, 8'hFF, 8'h11));
    req0_valid = 0;
    cycle("same_a1", 1, pk(0, 1, 1, 0, 0, 4'd9, 8'hFF, 8'h22));
    idle_inputs();
    chk("same_mem9", {24'd0, tbmem[9]}, 32'h22);

    // Random traffic obeying the hold-until-ready rule
    for (int c = 0; c < 400; c++) begin
      if (!req0_valid || mgrant == 0) begin
        req0_valid = ($urandom % 3) != 0;
        req0_addr = 4'($urandom);
        req0_wbe = ($urandom % 5 == 0) ? 8'h00 : 8'($urandom);
        req0_data = 8'($urandom);
      end
      if (!req1_valid || mgrant == 1) begin
        req1_valid = ($urandom % 3) != 0;
        req1_addr = 4'($urandom);
        req1_wbe = ($urandom % 5 == 0) ? 8'h00 : 8'($urandom);
        req1_data = 8'($urandom);
      end
      clr_req = ($urandom % 40) == 0;
      cycle("rand", 0, '0);
    end
    idle_inputs();
    for (int c = 0; c < 20; c++) cycle("drain", 0, '0);
    mem_vs_model("rand_mem");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
